// File: rtl/commit_store_buffer.sv
// commit_store_buffer
//   In-order store buffer behind the ROB store-commit interface. LSU stores
//   enter as speculative entries, are marked committed oldest-first, and
//   committed entries drain to the dcache over a req/addr_ok handshake.
//   A flush discards the speculative entries. A load whose word address
//   aliases any buffered store raises ld_conflict.
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   flush                            pipeline flush
//   enq_valid/enq_ready              store enqueue handshake
//   enq_addr/enq_data/enq_wstrb      store payload
//   commit_store1/2_valid            commit oldest one or two speculative stores
//   ld_check_addr/ld_conflict        load alias check (combinational)
//   dc_req/dc_addr/dc_wdata/dc_wstrb head-entry write request to dcache
//   dc_addr_ok                       dcache accepts the request
//   sb_empty                         no entries held
module commit_store_buffer #(
    parameter int SB_DEPTH = 8,
    parameter int PTR_W    = $clog2(SB_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [31:0] enq_addr,
    input  logic [31:0] enq_data,
    input  logic [3:0]  enq_wstrb,
    input  logic        commit_store1_valid,
    input  logic        commit_store2_valid,
    input  logic [31:0] ld_check_addr,
    output logic        ld_conflict,
    output logic        dc_req,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_wstrb,
    input  logic        dc_addr_ok,
    output logic        sb_empty
);
    localparam int CW = PTR_W + 1;

    typedef enum logic [1:0] {E_FREE, E_SPEC, E_CMT} ent_state_e;

    ent_state_e       st_q [SB_DEPTH];
    ent_state_e       st_d [SB_DEPTH];
    logic [31:0]      addr_q [SB_DEPTH];
    logic [31:0]      data_q [SB_DEPTH];
    logic [3:0]       strb_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, ncmt_q, ncmt_d, nspec;
    logic [1:0]       n_cmt;
    logic             commit2, enq_fire, drain_fire;
    logic             unused_ld_lsb;

    // store2 only counts when store1 is also present
    assign commit2    = commit_store1_valid && commit_store2_valid;
    assign n_cmt      = {1'b0, commit_store1_valid} + {1'b0, commit2};
    assign nspec      = count_q - ncmt_q;

    assign enq_ready  = (count_q != CW'(SB_DEPTH));
    assign sb_empty   = (count_q == '0);
    assign dc_req     = (st_q[head_q] == E_CMT);
    assign dc_addr    = dc_req ? addr_q[head_q] : '0;
    assign dc_wdata   = dc_req ? data_q[head_q] : '0;
    assign dc_wstrb   = dc_req ? strb_q[head_q] : '0;

    assign enq_fire   = enq_valid && enq_ready && !flush;
    assign drain_fire = dc_req && dc_addr_ok;

    assign unused_ld_lsb = ^ld_check_addr[1:0];

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (st_q[i] != E_FREE && addr_q[i][31:2] == ld_check_addr[31:2] &&
                strb_q[i] != 4'b0)
                ld_conflict = 1'b1;
        end
    end

    always_comb begin
        st_d    = st_q;
        head_d  = head_q + PTR_W'(drain_fire);
        cmt_d   = cmt_q + PTR_W'(n_cmt);
        ncmt_d  = ncmt_q + CW'(n_cmt) - CW'(drain_fire);
        tail_d  = tail_q;
        count_d = count_q;

        if (drain_fire)
            st_d[head_q] = E_FREE;
        if (commit_store1_valid)
            st_d[cmt_q] = E_CMT;
        if (commit2)
            st_d[cmt_q + PTR_W'(1)] = E_CMT;

        if (flush) begin
            // commits of this cycle are already marked, so only truly
            // speculative stores are dropped; what remains is committed work
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (st_d[i] == E_SPEC)
                    st_d[i] = E_FREE;
            end
            tail_d  = cmt_d;
            count_d = ncmt_d;
        end else begin
            if (enq_fire) begin
                st_d[tail_q] = E_SPEC;
                tail_d       = tail_q + PTR_W'(1);
            end
            count_d = count_q + CW'(enq_fire) - CW'(drain_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                st_q[i]   <= E_FREE;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ncmt_q  <= '0;
        end else begin
            st_q    <= st_d;
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ncmt_q  <= ncmt_d;
            if (enq_fire) begin
                addr_q[tail_q] <= enq_addr;
                data_q[tail_q] <= enq_data;
                strb_q[tail_q] <= enq_wstrb;
            end
        end
    end

    // commit protocol checks: store2 needs store1, and enough SPEC entries must exist
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(commit_store2_valid && !commit_store1_valid));
            assert (!commit_store1_valid || nspec >= CW'(n_cmt));
        end
    end

endmodule

// File: tb/tb_commit_store_buffer.sv
// tb_commit_store_buffer
//   Drives directed and random traffic into commit_store_buffer. A reference
//   model keeps speculative and committed stores as plain queues; committed
//   stores are pushed to a scoreboard that a negedge monitor compares against
//   the dcache request whenever the DUT presents one.
module tb_commit_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_addr = '0;
    logic [31:0] enq_data = '0;
    logic [3:0]  enq_wstrb = '0;
    logic        commit_store1_valid = 1'b0;
    logic        commit_store2_valid = 1'b0;
    logic [31:0] ld_check_addr = '0;
    logic        ld_conflict;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_addr_ok = 1'b0;
    logic        sb_empty;

    commit_store_buffer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_wstrb(enq_wstrb),
        .commit_store1_valid(commit_store1_valid),
        .commit_store2_valid(commit_store2_valid),
        .ld_check_addr(ld_check_addr), .ld_conflict(ld_conflict),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
        .dc_addr_ok(dc_addr_ok), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t spec_l[$];
    ent_t com_l[$];
    ent_t exp_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic conflict_m(input logic [31:0] la);
        foreach (spec_l[i])
            if (spec_l[i].a[31:2] == la[31:2] && spec_l[i].s != 4'b0) return 1'b1;
        foreach (com_l[i])
            if (com_l[i].a[31:2] == la[31:2] && com_l[i].s != 4'b0) return 1'b1;
        return 1'b0;
    endfunction

    // monitor: state-derived outputs against the model, drain payload against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            chk("enq_ready", {31'b0, enq_ready}, {31'b0, (spec_l.size() + com_l.size()) < 8});
            chk("sb_empty", {31'b0, sb_empty}, {31'b0, (spec_l.size() + com_l.size()) == 0});
            chk("dc_req", {31'b0, dc_req}, {31'b0, com_l.size() > 0});
            chk("ld_conflict", {31'b0, ld_conflict}, {31'b0, conflict_m(ld_check_addr)});
            if (dc_req) begin
                if (exp_q.size() == 0) begin
                    chk("drain_unexpected", {31'b0, dc_req}, 32'd0);
                end else begin
                    chk("dc_addr", dc_addr, exp_q[0].a);
                    chk("dc_wdata", dc_wdata, exp_q[0].d);
                    chk("dc_wstrb", {28'b0, dc_wstrb}, {28'b0, exp_q[0].s});
                    if (dc_addr_ok) void'(exp_q.pop_front());
                end
            end
        end
    end

    // one clock of stimulus; the model advances after the edge that applies it
    task automatic step(input logic ev, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic c1, input logic c2,
                        input logic fl, input logic ok, input logic [31:0] ld);
        int   cnt;
        ent_t e;
        enq_valid = ev; enq_addr = a; enq_data = d; enq_wstrb = s;
        commit_store1_valid = c1; commit_store2_valid = c2;
        flush = fl; dc_addr_ok = ok; ld_check_addr = ld;
        @(posedge clk);
        #1;
        cnt = spec_l.size() + com_l.size();
        if (com_l.size() > 0 && ok) void'(com_l.pop_front());
        if (c1) begin
            e = spec_l.pop_front(); com_l.push_back(e); exp_q.push_back(e);
            if (c2) begin
                e = spec_l.pop_front(); com_l.push_back(e); exp_q.push_back(e);
            end
        end
        if (fl) spec_l.delete();
        else if (ev && cnt < 8) begin
            e.a = a; e.d = d; e.s = s;
            spec_l.push_back(e);
        end
    endtask

    task automatic idle(input logic ok);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, ok, '0);
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        step(1'b1, a, d, s, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enq_valid = 1'b0; commit_store1_valid = 1'b0; commit_store2_valid = 1'b0;
        flush = 1'b0; dc_addr_ok = 1'b0; ld_check_addr = '0;
        @(posedge clk);
        #1;
        spec_l.delete(); com_l.delete(); exp_q.delete();
        reset = 1'b0;
        chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("rst_dc_req", {31'b0, dc_req}, 32'd0);
        chk("rst_ld_conflict", {31'b0, ld_conflict}, 32'd0);
        chk("rst_dc_addr", dc_addr, 32'd0);
        chk("rst_dc_wdata", dc_wdata, 32'd0);
        chk("rst_dc_wstrb", {28'b0, dc_wstrb}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rd, rl;
        logic [3:0]  rs;
        logic        rev, rc1, rc2, rfl, rok;

        repeat (2) @(posedge clk);
        do_reset();

        // single store: enqueue, commit, drain
        enq(32'h100, 32'hAABBCCDD, 4'hF);
        chk("t1_no_req_spec", {31'b0, dc_req}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("t1_req_after_commit", {31'b0, dc_req}, 32'd1);
        chk("t1_dc_addr", dc_addr, 32'h100);
        chk("t1_dc_wdata", dc_wdata, 32'hAABBCCDD);
        idle(1'b1);
        chk("t1_empty", {31'b0, sb_empty}, 32'd1);

        // fill to full, reject the 9th, free two slots
        for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(i * 4), 32'h11110000 + 32'(i), 4'hF);
        chk("t2_full", {31'b0, enq_ready}, 32'd0);
        enq(32'h2000, 32'hDEADBEEF, 4'hF);
        chk("t2_still_full", {31'b0, enq_ready}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        chk("t2_ready_again", {31'b0, enq_ready}, 32'd1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("t2_flushed_empty", {31'b0, sb_empty}, 32'd1);

        // commit one of four, flush the rest, committed one still drains
        for (int i = 0; i < 4; i++) enq(32'h300 + 32'(i * 4), 32'h33000000 + 32'(i), 4'h3);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("t3_one_left", {31'b0, sb_empty}, 32'd0);
        idle(1'b1);
        chk("t3_empty", {31'b0, sb_empty}, 32'd1);

        // commit2 together with flush on three SPEC entries
        for (int i = 0; i < 3; i++) enq(32'h400 + 32'(i * 4), 32'h44000000 + 32'(i), 4'hC);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        chk("t4_empty", {31'b0, sb_empty}, 32'd1);

        // backpressure: request held stable while dc_addr_ok is low
        enq(32'h500, 32'h55667788, 4'h6);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("t5_req_held", {31'b0, dc_req}, 32'd1);
            chk("t5_addr_held", dc_addr, 32'h500);
        end
        idle(1'b1);
        chk("t5_empty", {31'b0, sb_empty}, 32'd1);

        // load alias against a speculative store
        enq(32'h204, 32'h12345678, 4'hF);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h206);
        chk("t6_conflict", {31'b0, ld_conflict}, 32'd1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208);
        chk("t6_no_conflict", {31'b0, ld_conflict}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // pointer wrap keeps FIFO order
        for (int i = 0; i < 20; i++) begin
            enq(32'h6000 + 32'(i * 4), 32'h66000000 + 32'(i), 4'(i));
            step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            idle(1'b1);
        end
        chk("t6_wrap_empty", {31'b0, sb_empty}, 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            ra  = 32'h200 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            rd  = $urandom;
            rs  = 4'($urandom_range(0, 15));
            rl  = 32'h200 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            rev = ($urandom_range(0, 9) < 6);
            rc1 = (spec_l.size() >= 1) && ($urandom_range(0, 9) < 4);
            rc2 = rc1 && (spec_l.size() >= 2) && ($urandom_range(0, 1) == 1);
            rfl = ($urandom_range(0, 99) < 4);
            rok = ($urandom_range(0, 9) < 6);
            step(rev, ra, rd, rs, rc1, rc2, rfl, rok, rl);
        end

        // reset while a committed store is waiting to drain
        enq(32'h700, 32'h77777777, 4'hF);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t7_pending", {31'b0, dc_req}, 32'd1);
        do_reset();
        idle(1'b1);
        chk("t7_lost", {31'b0, dc_req}, 32'd0);
        chk("t7_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
